dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the load/store interface driven by the datapath's memory stage.
- Accepts one LDUR/STUR request at a time over a valid/ready handshake.
- Waits a programmable number of cycles to model memory latency, then returns read data or a write acknowledgement over a valid/ready response channel.
- Replaces the zero-latency array model so the pipeline can be exercised against stalling memory.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 113 +++++++++++
 tb/tb_dmem_responder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the memory stage
// (initiator) and the data-memory responder.
interface dmem_responder_if #(
  parameter int WORD = 64
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [WORD-1:0] req_addr;
  logic [WORD-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [WORD-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable access latency.
// One LDUR/STUR in flight; the access is performed after LATENCY wait
// cycles and the result is presented on the response channel.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a request; no response pending
//   WAIT  | request latched, counting down the modelled latency
//   RESP  | access done, response held until the initiator takes it
module dmem_responder #(
  parameter int WORD    = 64,
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    dmem
);

  localparam int              IDXW = $clog2(DEPTH);
  localparam logic [3:0]      LAT  = 4'(LATENCY);
  localparam logic [WORD-4:0] LIM  = (WORD-3)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q;
  logic            wr_q;
  logic [WORD-1:0] addr_q;
  logic [WORD-1:0] wdata_q;
  logic [WORD-1:0] rdata_q;
  logic            err_q;

  logic [WORD-1:0] mem [DEPTH];

  logic            accept;
  logic            do_access;
  logic            bad;
  logic [WORD-4:0] word_idx;
  logic [IDXW-1:0] idx;

  assign accept    = (state_q == IDLE) && dmem.req_valid;
  assign do_access = (state_q == WAIT) && (cnt_q == 4'd0);

  // Index is the full upper address so large addresses never alias back
  // into the array; only the low bits are used once the range check passes.
  assign word_idx = addr_q[WORD-1:3];
  assign idx      = addr_q[IDXW+2:3];
  assign bad      = (addr_q[2:0] != 3'd0) || (word_idx >= LIM);

  assign dmem.req_ready = (state_q == IDLE);
  assign dmem.rsp_valid = (state_q == RESP);
  assign dmem.rsp_rdata = rdata_q;
  assign dmem.rsp_err   = err_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (dmem.req_valid) state_d = WAIT;
      WAIT: if (cnt_q == 4'd0)  state_d = RESP;
      RESP: if (dmem.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, latency counter and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= dmem.req_write;
        addr_q  <= dmem.req_addr;
        wdata_q <= dmem.req_wdata;
        cnt_q   <= LAT;
      end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (do_access) begin
        err_q   <= bad;
        rdata_q <= (bad || wr_q) ? '0 : mem[idx];
      end
    end
  end

  // Storage array; not reset. A reset while waiting leaves the state
  // machine out of WAIT, so an abandoned store never reaches the array.
  always_ff @(posedge clk) begin
    if (do_access && wr_q && !bad) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WORD=64, DEPTH=128, LATENCY=2).
module tb_dmem_responder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   edges;

  dmem_responder_if #(.WORD(64)) bus();

  dmem_responder #(.WORD(64), .DEPTH(128), .LATENCY(2)) dut (
    .clk   (clk),
    .reset (rst_n),
    .dmem  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request, scramble the inputs right after acceptance, then
  // count edges from the accept edge until rsp_valid is seen (bounded).
  task automatic send(input logic w, input logic [63:0] a, input logic [63:0] d,
                      output int n);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = ~w;
    bus.req_addr  = a ^ 64'h8;
    bus.req_wdata = ~d;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
      @(posedge clk);
      n++;
    end
  endtask

  // Take the pending response with a one-cycle rsp_ready pulse.
  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_rsp_err",   {63'd0, bus.rsp_err},   64'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata,          64'd0);
    rst_n = 1'b1;

    // Seed word 0 and word 2.
    send(1'b1, 64'h0, 64'h1111_2222_3333_4444, edges);
    chk("st0_latency", 64'(edges), 64'd3);
    chk("st0_err",   {63'd0, bus.rsp_err}, 64'd0);
    chk("st0_rdata", bus.rsp_rdata, 64'd0);
    consume();

    send(1'b1, 64'h10, 64'h0000_0000_DEAD_BEEF, edges);
    chk("st10_latency", 64'(edges), 64'd3);
    chk("st10_err",     {63'd0, bus.rsp_err}, 64'd0);
    chk("st10_ready_busy", {63'd0, bus.req_ready}, 64'd0);
    consume();
    chk("st10_done_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("st10_done_ready", {63'd0, bus.req_ready}, 64'd1);

    // Read-after-write.
    send(1'b0, 64'h10, 64'h0, edges);
    chk("ld10_latency", 64'(edges), 64'd3);
    chk("ld10_rdata", bus.rsp_rdata, 64'h0000_0000_DEAD_BEEF);
    chk("ld10_err",   {63'd0, bus.rsp_err}, 64'd0);
    consume();
    chk("ld10_hold_rdata", bus.rsp_rdata, 64'h0000_0000_DEAD_BEEF);

    // Misaligned load.
    send(1'b0, 64'h13, 64'h0, edges);
    chk("mis_err",   {63'd0, bus.rsp_err}, 64'd1);
    chk("mis_rdata", bus.rsp_rdata, 64'd0);
    consume();

    // Out-of-range store must not wrap onto word 0.
    send(1'b1, 64'h400, 64'h0BAD, edges);
    chk("oor_st_err",   {63'd0, bus.rsp_err}, 64'd1);
    chk("oor_st_rdata", bus.rsp_rdata, 64'd0);
    consume();
    send(1'b0, 64'h0, 64'h0, edges);
    chk("ld0_rdata", bus.rsp_rdata, 64'h1111_2222_3333_4444);
    chk("ld0_err",   {63'd0, bus.rsp_err}, 64'd0);
    consume();

    // Very high address: upper bits must count in the range check.
    send(1'b0, 64'h8000_0000_0000_0010, 64'h0, edges);
    chk("hi_err",   {63'd0, bus.rsp_err}, 64'd1);
    chk("hi_rdata", bus.rsp_rdata, 64'd0);
    consume();

    // Back-pressure with a stray request during RESP.
    send(1'b0, 64'h10, 64'h0, edges);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 64'h10;
        bus.req_wdata = 64'h999;
      end
      if (i == 3) bus.req_valid = 1'b0;
      @(negedge clk);
      chk("bp_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("bp_rdata", bus.rsp_rdata, 64'h0000_0000_DEAD_BEEF);
      chk("bp_ready", {63'd0, bus.req_ready}, 64'd0);
    end
    consume();
    chk("bp_after_ready", {63'd0, bus.req_ready}, 64'd1);
    @(negedge clk);
    chk("bp_no_stray", {63'd0, bus.rsp_valid}, 64'd0);
    chk("bp_idle_ready", {63'd0, bus.req_ready}, 64'd1);
    send(1'b0, 64'h10, 64'h0, edges);
    chk("bp_ld10_rdata", bus.rsp_rdata, 64'h0000_0000_DEAD_BEEF);
    consume();

    // Reset while waiting abandons the store.
    send(1'b1, 64'h20, 64'h77, edges);
    consume();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 64'h20;
    bus.req_wdata = 64'h55;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("wait_ready_busy", {63'd0, bus.req_ready}, 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("wrst_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("wrst_valid", {63'd0, bus.rsp_valid}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 64'h20, 64'h0, edges);
    chk("wrst_ld20", bus.rsp_rdata, 64'h77);
    consume();

    // Reset while a load response is pending clears outputs at once.
    send(1'b0, 64'h10, 64'h0, edges);
    chk("rrst_pre_rdata", bus.rsp_rdata, 64'h0000_0000_DEAD_BEEF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rrst_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rrst_rdata", bus.rsp_rdata, 64'd0);
    chk("rrst_err",   {63'd0, bus.rsp_err},   64'd0);
    chk("rrst_ready", {63'd0, bus.req_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 64'h10, 64'h0, edges);
    chk("rrst_ld10", bus.rsp_rdata, 64'h0000_0000_DEAD_BEEF);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
